// File: rtl/excitation_source_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : excitation_source_pkg
//  Purpose  : Shared constants, FSM state encoding and amplitude-scaling
//             helper for the excitation source and its noise LFSR.
//  Revision : 1.0  initial release
// ============================================================================
package excitation_source_pkg;

  // Noise generator: 17-bit Fibonacci LFSR, polynomial x^17 + x^14 + 1
  localparam int          c_lfsr_width     = 17;
  localparam logic [16:0] c_lfsr_seed      = 17'h1;
  // Tap offset of the x^14 term relative to the output bit (17 - 14)
  localparam int          c_lfsr_tap       = 3;

  // Default left shift that turns the 8-bit amplitude into a 16-bit sample
  localparam int          c_amp_shift      = 5;

  // Sample and parameter widths
  localparam int          c_sample_width   = 16;
  localparam int          c_param_width    = 8;

  // Handshake FSM: IDLE waits for a sample tick, WAIT waits for filter done
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Unsigned amplitude widened to the sample width and shifted into place
  function automatic logic [15:0] scale_amp(input logic [7:0] amp,
                                            input int unsigned shift);
    logic [15:0] wide;
    wide = {8'd0, amp};
    return wide << shift;
  endfunction

endpackage : excitation_source_pkg
`default_nettype wire

// File: rtl/excitation_source_noise_lfsr.sv
`default_nettype none
// ============================================================================
//  Module   : noise_lfsr
//  Purpose  : 17-bit Fibonacci LFSR (x^17 + x^14 + 1) that supplies one
//             pseudo-random sign bit per step for unvoiced excitation.
//  Revision : 1.0  initial release
// ============================================================================
module noise_lfsr
  import excitation_source_pkg::*;
#(
  parameter logic [16:0] SEED = c_lfsr_seed
) (
  input  logic clk,
  input  logic rst_an,
  input  logic step,
  output logic bit_out
);

  logic [c_lfsr_width-1:0] r_lfsr;
  logic                    w_feedback;

  // Feedback combines the output bit with the x^14 tap
  assign w_feedback = r_lfsr[0] ^ r_lfsr[c_lfsr_tap];

  // Shift toward bit 0 once per step; new bit enters at the top
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      r_lfsr <= SEED;
    end else if (step) begin
      r_lfsr <= {w_feedback, r_lfsr[c_lfsr_width-1:1]};
    end
  end

  assign bit_out = r_lfsr[0];

endmodule : noise_lfsr
`default_nettype wire

// File: rtl/excitation_source.sv
`default_nettype none
// ============================================================================
//  Module   : excitation_source
//  Purpose  : Excitation stream for the all-pole filter: a periodic impulse
//             train when voiced, LFSR white noise when period is zero. One
//             sample per accepted sample_tick, handed over with start/done.
//  Revision : 1.0  initial release
// ============================================================================
module excitation_source
  import excitation_source_pkg::*;
#(
  parameter int unsigned AMP_SHIFT = c_amp_shift,
  parameter logic [16:0] LFSR_SEED = c_lfsr_seed
) (
  input  logic                     clk,
  input  logic                     rst_an,
  input  logic [7:0]               period,
  input  logic [7:0]               amplitude,
  input  logic                     param_load,
  input  logic                     sample_tick,
  input  logic                     done,
  output logic signed [15:0]       sig_out,
  output logic                     start,
  output logic                     overrun
);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t                          r_state;
  logic [c_param_width-1:0]        r_period_sh;
  logic [c_param_width-1:0]        r_amp_sh;
  logic [c_param_width-1:0]        r_period_act;
  logic [c_param_width-1:0]        r_amp_act;
  logic [c_param_width-1:0]        r_pcnt;
  logic [c_sample_width-1:0]       r_sig_out;
  logic                            r_start;
  logic                            r_overrun;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  state_t                          w_state_next;
  logic                            w_start_next;
  logic                            w_accept;
  logic                            w_drop;
  logic [c_param_width-1:0]        w_period_eff;
  logic [c_param_width-1:0]        w_amp_eff;
  logic [c_param_width-1:0]        w_period_m1;
  logic                            w_voiced;
  logic [c_sample_width-1:0]       w_mag;
  logic [c_sample_width-1:0]       w_sample;
  logic [c_param_width-1:0]        w_pcnt_next;
  logic                            w_noise_bit;
  logic                            w_lfsr_step;

  // A tick is only accepted while the filter is idle; in WAIT it is dropped
  assign w_accept = (r_state == ST_IDLE) && sample_tick;
  assign w_drop   = (r_state == ST_WAIT) && sample_tick;

  // A load in the same cycle as the tick wins over the older shadow contents
  assign w_period_eff = param_load ? period    : r_period_sh;
  assign w_amp_eff    = param_load ? amplitude : r_amp_sh;

  assign w_voiced    = (w_period_eff != '0);
  assign w_period_m1 = w_period_eff - 8'd1;
  assign w_mag       = scale_amp(w_amp_eff, AMP_SHIFT);

  // Noise only consumes an LFSR step when a noise sample is actually produced
  assign w_lfsr_step = w_accept && !w_voiced;

  noise_lfsr #(
    .SEED    (LFSR_SEED)
  ) u_noise_lfsr (
    .clk     (clk),
    .rst_an  (rst_an),
    .step    (w_lfsr_step),
    .bit_out (w_noise_bit)
  );

  // Sample value and pitch counter successor for the tick being accepted
  always_comb begin
    w_sample    = '0;
    w_pcnt_next = '0;
    if (w_voiced) begin
      w_sample    = (r_pcnt == '0) ? w_mag : '0;
      // >= rather than == so a shrinking period wraps immediately
      w_pcnt_next = (r_pcnt >= w_period_m1) ? '0 : r_pcnt + 8'd1;
    end else begin
      // Magnitude never exceeds 8160, so negation cannot overflow
      w_sample    = w_noise_bit ? (16'd0 - w_mag) : w_mag;
      w_pcnt_next = '0;
    end
  end

  // Handshake FSM state register
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Handshake FSM next state and start request; done is ignored while idle
  always_comb begin
    w_state_next = r_state;
    w_start_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sample_tick) begin
          w_state_next = ST_WAIT;
          w_start_next = 1'b1;
        end
      end
      ST_WAIT: begin
        if (done) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Shadow parameters follow every load strobe
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      r_period_sh <= '0;
      r_amp_sh    <= '0;
    end else if (param_load) begin
      r_period_sh <= period;
      r_amp_sh    <= amplitude;
    end
  end

  // Active parameters and pitch counter advance only on an accepted tick
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      r_period_act <= '0;
      r_amp_act    <= '0;
      r_pcnt       <= '0;
    end else if (w_accept) begin
      r_period_act <= w_period_eff;
      r_amp_act    <= w_amp_eff;
      r_pcnt       <= w_pcnt_next;
    end
  end

  // Output sample held until the next accepted tick; start is a 1-cycle pulse
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      r_sig_out <= '0;
      r_start   <= 1'b0;
    end else begin
      r_start <= w_start_next;
      if (w_accept) begin
        r_sig_out <= w_sample;
      end
    end
  end

  // Overrun is sticky: any tick that lands while the filter is busy
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end
  end

  assign sig_out = r_sig_out;
  assign start   = r_start;
  assign overrun = r_overrun;

  // Active copies are kept for observability of the parameters in use
  logic w_unused_act;
  assign w_unused_act = ^{r_period_act, r_amp_act};

endmodule : excitation_source
`default_nettype wire

// File: tb/tb_excitation_source.sv
`default_nettype none
// ============================================================================
//  Module   : tb_excitation_source
//  Purpose  : Directed, scoreboard-checked bench for excitation_source.
//  Revision : 1.0  initial release
// ============================================================================
module tb_excitation_source;

  logic               clk = 1'b0;
  logic               rst_an;
  logic [7:0]         period;
  logic [7:0]         amplitude;
  logic               param_load;
  logic               sample_tick;
  logic               done;
  logic signed [15:0] sig_out;
  logic               start;
  logic               overrun;

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [15:0] exp_q[$];
  logic signed [15:0] mon_exp;
  // Noise reference: bit sequence b[n+17] = b[n] ^ b[n+3]; window front is b[n]
  int                 nz_bits[$];

  excitation_source dut (
    .clk         (clk),
    .rst_an      (rst_an),
    .period      (period),
    .amplitude   (amplitude),
    .param_load  (param_load),
    .sample_tick (sample_tick),
    .done        (done),
    .sig_out     (sig_out),
    .start       (start),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every start pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_an === 1'b1 && start === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_start: got start with sig_out=%0d, expected no start", sig_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (sig_out !== mon_exp) begin
          n_fail++;
          $display("FAIL sample: got sig_out=%0d, expected %0d", sig_out, mon_exp);
        end
      end
    end
  end

  task automatic nz_reset();
    nz_bits.delete();
    nz_bits.push_back(1);
    for (int i = 1; i < 17; i++) nz_bits.push_back(0);
  endtask

  // Expected noise sample for the next accepted tick, then advance the reference
  function automatic int nz_sample(input int amp);
    int v;
    v = (nz_bits[0] != 0) ? -(amp * 32) : (amp * 32);
    nz_bits.push_back(nz_bits[0] ^ nz_bits[3]);
    void'(nz_bits.pop_front());
    return v;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_an = 1'b0;
    nz_reset();
    repeat (2) @(negedge clk);
    rst_an = 1'b1;
  endtask

  task automatic load(input int p, input int a);
    @(negedge clk);
    period = 8'(p); amplitude = 8'(a); param_load = 1'b1;
    @(negedge clk);
    param_load = 1'b0;
  endtask

  task automatic tick_exp(input int req);
    @(negedge clk);
    sample_tick = 1'b1;
    exp_q.push_back(16'(req));
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic tick_drop();
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic give_done(input int lat);
    repeat (lat) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  initial begin
    rst_an = 1'b0; period = '0; amplitude = '0;
    param_load = 1'b0; sample_tick = 1'b0; done = 1'b0;
    nz_reset();

    // 1. Reset state, then start timing relative to the tick edge
    repeat (3) @(negedge clk);
    check("reset_sig_out", int'(sig_out), 0);
    check("reset_start", int'(start), 0);
    check("reset_overrun", int'(overrun), 0);
    rst_an = 1'b1;
    @(negedge clk);
    sample_tick = 1'b1;
    exp_q.push_back(16'(nz_sample(0)));
    @(posedge clk); #1;
    check("start_after_tick_edge", int'(start), 1);
    @(negedge clk);
    sample_tick = 1'b0;
    @(posedge clk); #1;
    check("start_one_cycle", int'(start), 0);
    give_done(3);

    // 2. Voiced impulse train, period 4
    load(4, 100);
    for (int i = 0; i < 12; i++) begin
      tick_exp((i % 4 == 0) ? 3200 : 0);
      give_done(20);
    end

    // 3. Noise from a fresh seed, then noise -> voiced starts on a pulse
    apply_reset();
    load(0, 10);
    for (int i = 0; i < 17; i++) begin
      tick_exp(nz_sample(10));
      give_done(2);
    end
    load(4, 100);
    tick_exp(3200);
    give_done(2);

    // 5. Period shrink clamps the counter; amplitude 0 still issues start
    apply_reset();
    load(8, 100);
    for (int i = 0; i < 6; i++) begin
      tick_exp((i == 0) ? 3200 : 0);
      give_done(3);
    end
    load(3, 100);
    tick_exp(0);
    give_done(3);
    tick_exp(3200);
    give_done(3);
    load(3, 0);
    tick_exp(0); give_done(3);
    tick_exp(0); give_done(3);
    tick_exp(0); give_done(3);

    // 4. Ticks while the filter is busy are dropped and latch overrun
    load(2, 50);
    tick_exp(0);                  // pcnt 1 wraps to 0
    check("overrun_before", int'(overrun), 0);
    repeat (2) @(negedge clk);
    tick_drop();
    check("overrun_set", int'(overrun), 1);
    give_done(2);
    tick_exp(1600);
    @(negedge clk);
    done = 1'b1; sample_tick = 1'b1;   // done and tick together: tick dropped
    @(negedge clk);
    done = 1'b0; sample_tick = 1'b0;
    check("overrun_sticky_done", int'(overrun), 1);
    tick_exp(0);
    give_done(2);
    check("overrun_sticky_tick", int'(overrun), 1);

    // 6. Asynchronous reset while start is high in WAIT
    @(negedge clk);
    sample_tick = 1'b1;
    @(posedge clk); #1;
    check("pre_reset_start", int'(start), 1);
    check("pre_reset_sample", int'(sig_out), 1600);
    rst_an = 1'b0;
    sample_tick = 1'b0;
    #1;
    check("async_reset_start", int'(start), 0);
    check("async_reset_sig_out", int'(sig_out), 0);
    check("async_reset_overrun", int'(overrun), 0);
    nz_reset();
    repeat (2) @(negedge clk);
    rst_an = 1'b1;
    repeat (4) @(negedge clk);
    // Load and tick in the same cycle: the new values apply to this sample
    @(negedge clk);
    period = 8'd4; amplitude = 8'd100; param_load = 1'b1; sample_tick = 1'b1;
    exp_q.push_back(16'sd3200);
    @(negedge clk);
    param_load = 1'b0; sample_tick = 1'b0;
    give_done(2);
    tick_exp(0);
    give_done(2);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_excitation_source
`default_nettype wire
